// File: rtl/imem_loadable.sv
// -----------------------------------------------------------------------------
// imem_loadable
// Instruction memory for the processor core. It has a registered fetch port with
// a one-cycle latency and a stall/hold handshake. It also has a sequential
// program-loader port that streams words into consecutive addresses at runtime.
//
// Ports
//   clk, reset         : system clock, synchronous active-high reset
//   fetch_req/addr     : fetch request and word address (taken when fetch_ready)
//   fetch_stall        : consumer not accepting; hold the current fetch output
//   fetch_ready        : a fetch can be accepted this cycle
//   fetch_valid/data   : registered fetch result
//   ld_start/base      : open a load session at ld_base (ignored while loading)
//   ld_valid/data/last : word stream; ld_last closes the session
//   ld_busy            : load session in progress
//   ld_done            : one-cycle pulse when a session closes normally
//   ld_count           : words written in the current or most recent session
// -----------------------------------------------------------------------------
module imem_loadable #(
  parameter int    IW        = 9,
  parameter int    AW        = 10,
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  input  logic          fetch_stall,
  output logic          fetch_ready,
  output logic          fetch_valid,
  output logic [IW-1:0] fetch_data,
  input  logic          ld_start,
  input  logic [AW-1:0] ld_base,
  input  logic          ld_valid,
  input  logic [IW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_busy,
  output logic          ld_done,
  output logic [AW:0]   ld_count
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  logic [IW-1:0] r_mem [0:(2**AW)-1];

  state_t        r_state;
  logic [AW-1:0] r_ptr;
  logic [AW:0]   r_ld_count;
  logic          r_ld_done;
  logic          r_fetch_valid;
  logic [IW-1:0] r_fetch_data;

  logic w_hold;
  logic w_fetch_ready;
  logic w_accept;
  logic w_wr;
  logic w_end;

  // The consumer holds the current word while it stalls. Fetches are also
  // blocked while loading, so a read never collides with a loader write.
  assign w_hold        = r_fetch_valid && fetch_stall;
  assign w_fetch_ready = (r_state == S_IDLE) && !w_hold;
  assign w_accept      = fetch_req && w_fetch_ready;

  // A session closes on ld_last or on writing the top address. It never
  // wraps into low memory.
  assign w_wr  = (r_state == S_LOAD) && ld_valid;
  assign w_end = w_wr && (ld_last || (r_ptr == {AW{1'b1}}));

  // Storage is never cleared by reset; a write on the reset edge is dropped.
  always_ff @(posedge clk) begin
    if (w_wr && !reset) begin
      r_mem[r_ptr] <= ld_data;
    end
  end

  // Fetch pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_valid <= 1'b0;
      r_fetch_data  <= '0;
    end else if (w_accept) begin
      r_fetch_valid <= 1'b1;
      r_fetch_data  <= r_mem[fetch_addr];
    end else if (!w_hold) begin
      r_fetch_valid <= 1'b0;
    end
  end

  // Loader FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_ld_count <= '0;
      r_ld_done  <= 1'b0;
    end else begin
      r_ld_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ld_start) begin
            r_state    <= S_LOAD;
            r_ptr      <= ld_base;
            r_ld_count <= '0;
          end
        end
        S_LOAD: begin
          if (w_wr) begin
            r_ptr      <= r_ptr + {{(AW-1){1'b0}}, 1'b1};
            r_ld_count <= r_ld_count + {{AW{1'b0}}, 1'b1};
            if (w_end) begin
              r_state   <= S_IDLE;
              r_ld_done <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign fetch_ready = w_fetch_ready;
  assign fetch_valid = r_fetch_valid;
  assign fetch_data  = r_fetch_data;
  assign ld_busy     = (r_state == S_LOAD);
  assign ld_done     = r_ld_done;
  assign ld_count    = r_ld_count;

endmodule

// File: tb/tb_imem_loadable.sv
// -----------------------------------------------------------------------------
// tb_imem_loadable
// Self-checking bench for imem_loadable. A behavioural model holds the memory
// image and the expected port state. It is compared against the DUT on every
// falling edge. Directed scenarios also check hand-computed literal values,
// and a randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_imem_loadable;

  localparam int IW    = 9;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_stall;
  logic          fetch_ready;
  logic          fetch_valid;
  logic [IW-1:0] fetch_data;
  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic          ld_valid;
  logic [IW-1:0] ld_data;
  logic          ld_last;
  logic          ld_busy;
  logic          ld_done;
  logic [AW:0]   ld_count;

  imem_loadable #(.IW(IW), .AW(AW), .INIT_FILE("")) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_stall(fetch_stall),
    .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid),
    .fetch_data (fetch_data),
    .ld_start   (ld_start),
    .ld_base    (ld_base),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_busy    (ld_busy),
    .ld_done    (ld_done),
    .ld_count   (ld_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. Memory entries of -1 have never been written.
  int m_mem [DEPTH];
  bit m_busy = 0, m_done = 0, m_fv = 0;
  int m_ptr = 0, m_cnt = 0, m_fd = 0;

  initial for (int i = 0; i < DEPTH; i++) m_mem[i] = -1;

  always @(posedge clk) begin
    bit hold;
    hold = m_fv && fetch_stall;
    if (reset) begin
      m_busy = 0; m_done = 0; m_fv = 0; m_fd = 0; m_ptr = 0; m_cnt = 0;
    end else begin
      // Fetch sees memory before any write on this edge.
      if (fetch_req && !m_busy && !hold) begin
        m_fv = 1;
        m_fd = m_mem[int'(fetch_addr)];
      end else if (!hold) begin
        m_fv = 0;
      end
      m_done = 0;
      if (!m_busy) begin
        if (ld_start) begin
          m_busy = 1; m_ptr = int'(ld_base); m_cnt = 0;
        end
      end else if (ld_valid) begin
        m_mem[m_ptr] = int'(ld_data);
        m_cnt = m_cnt + 1;
        if (ld_last || m_ptr == DEPTH - 1) begin
          m_busy = 0; m_done = 1;
        end
        m_ptr = (m_ptr + 1) % DEPTH;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ld_busy",     int'(ld_busy),     int'(m_busy));
      chk("ld_done",     int'(ld_done),     int'(m_done));
      chk("ld_count",    int'(ld_count),    m_cnt);
      chk("fetch_valid", int'(fetch_valid), int'(m_fv));
      chk("fetch_ready", int'(fetch_ready), int'(!m_busy && !(m_fv && fetch_stall)));
      if (m_fd >= 0) chk("fetch_data", int'(fetch_data), m_fd);
    end
  end

  // Advance one clock: return just after the following falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_req = 0; fetch_addr = '0; fetch_stall = 0;
    ld_start = 0; ld_base = '0; ld_valid = 0; ld_data = '0; ld_last = 0;
  endtask

  task automatic fetch_lit(input int addr, input int exp, input string name);
    fetch_req = 1; fetch_addr = AW'(addr);
    tick();
    fetch_req = 0;
    chk({name, "_valid"}, int'(fetch_valid), 1);
    chk(name, int'(fetch_data), exp);
  endtask

  task automatic start_load(input int base);
    ld_start = 1; ld_base = AW'(base);
    tick();
    ld_start = 0;
  endtask

  task automatic write_word(input int data, input bit last);
    ld_valid = 1; ld_data = IW'(data); ld_last = last;
    tick();
    ld_valid = 0; ld_last = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1;
    tick(); tick();
    chk_en = 1;
    chk("rst_fetch_valid", int'(fetch_valid), 0);
    chk("rst_fetch_data",  int'(fetch_data),  0);
    chk("rst_ld_busy",     int'(ld_busy),     0);
    chk("rst_ld_done",     int'(ld_done),     0);
    chk("rst_ld_count",    int'(ld_count),    0);
    reset = 0;
    tick();

    // Fill the whole memory with word i at address i, with random idle gaps.
    // With no ld_last the session closes at the top address.
    start_load(0);
    for (int i = 0; i < DEPTH; i++) begin
      if ($urandom_range(0, 7) == 0) tick();
      write_word(i, 1'b0);
    end
    chk("fill_done",  int'(ld_done),  1);
    chk("fill_busy",  int'(ld_busy),  0);
    chk("fill_count", int'(ld_count), 1024);
    tick();

    // Back-to-back fetches 0, 1, 2, 1023.
    fetch_req = 1; fetch_addr = 10'd0; #1;
    chk("b2b_ready0", int'(fetch_ready), 1);
    tick(); chk("b2b_d0", int'(fetch_data), 0);
    fetch_addr = 10'd1; #1;
    chk("b2b_ready1", int'(fetch_ready), 1);
    tick(); chk("b2b_d1", int'(fetch_data), 1);
    fetch_addr = 10'd2;
    tick(); chk("b2b_d2", int'(fetch_data), 2);
    fetch_addr = 10'd1023;
    tick(); chk("b2b_d3", int'(fetch_data), 'h1FF);
    chk("b2b_valid", int'(fetch_valid), 1);
    fetch_req = 0;
    tick();
    chk("b2b_drop_valid", int'(fetch_valid), 0);
    chk("b2b_hold_data",  int'(fetch_data), 'h1FF);

    // Stall holds address 5 while address 6 waits.
    fetch_lit(5, 5, "stall_first");
    fetch_req = 1; fetch_addr = 10'd6; fetch_stall = 1; #1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_ready", int'(fetch_ready), 0);
      tick();
      chk("stall_data",  int'(fetch_data), 5);
      chk("stall_valid", int'(fetch_valid), 1);
    end
    fetch_stall = 0;
    tick();
    chk("stall_next", int'(fetch_data), 6);
    fetch_req = 0;
    tick();

    // Three-word session at 0x010.
    start_load('h010);
    chk("ld3_busy0", int'(ld_busy), 1);
    write_word('h1AA, 0); chk("ld3_busy1", int'(ld_busy), 1);
    write_word('h055, 0); chk("ld3_busy2", int'(ld_busy), 1);
    write_word('h123, 1);
    chk("ld3_busy_end", int'(ld_busy), 0);
    chk("ld3_done",     int'(ld_done), 1);
    chk("ld3_count",    int'(ld_count), 3);
    tick();
    chk("ld3_done_pulse", int'(ld_done), 0);
    fetch_lit('h010, 'h1AA, "ld3_f0");
    fetch_lit('h011, 'h055, "ld3_f1");
    fetch_lit('h012, 'h123, "ld3_f2");
    tick();

    // Session at the top address stops without wrapping.
    start_load('h3FE);
    write_word('h1F0, 0);
    write_word('h1F1, 0);
    chk("top_done",  int'(ld_done),  1);
    chk("top_count", int'(ld_count), 2);
    write_word('h1F2, 0);
    chk("top_idle",  int'(ld_busy),  0);
    chk("top_count_keep", int'(ld_count), 2);
    fetch_lit('h3FE, 'h1F0, "top_f0");
    fetch_lit('h3FF, 'h1F1, "top_f1");
    fetch_lit(0, 0, "top_nowrap");
    tick();

    // Reset in the middle of a session.
    start_load('h100);
    write_word('h0AB, 0);
    write_word('h0CD, 0);
    reset = 1;
    tick();
    chk("mid_busy",  int'(ld_busy),  0);
    chk("mid_done",  int'(ld_done),  0);
    chk("mid_count", int'(ld_count), 0);
    reset = 0;
    tick();
    chk("mid_ready", int'(fetch_ready), 1);
    fetch_lit('h100, 'h0AB, "mid_f0");
    fetch_lit('h101, 'h0CD, "mid_f1");
    tick();

    // A fetch and ld_start in the same cycle: the fetch sees pre-load contents.
    start_load('h020);
    write_word('h0F0, 1);
    tick();
    ld_start = 1; ld_base = 10'h020; fetch_req = 1; fetch_addr = 10'h020;
    tick();
    ld_start = 0; fetch_req = 0;
    chk("same_old",  int'(fetch_data), 'h0F0);
    chk("same_busy", int'(ld_busy), 1);
    write_word('h111, 1);
    tick();
    fetch_lit('h020, 'h111, "same_new");
    tick();

    // Randomized phase; the model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 199) == 0);
      fetch_req   = $urandom_range(0, 3) != 0;
      fetch_addr  = AW'($urandom_range(0, DEPTH - 1));
      fetch_stall = $urandom_range(0, 3) == 0;
      ld_start    = $urandom_range(0, 29) == 0;
      ld_base     = ($urandom_range(0, 3) == 0) ? AW'(DEPTH - 1 - $urandom_range(0, 3))
                                                : AW'($urandom_range(0, DEPTH - 1));
      ld_valid    = $urandom_range(0, 1) == 1;
      ld_data     = IW'($urandom_range(0, (1 << IW) - 1));
      ld_last     = $urandom_range(0, 7) == 0;
      tick();
    end
    idle_inputs();
    reset = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
